neo_sdram_port_arbiter: RTL and testbench
=========================================

# neo_sdram_port_arbiter

Shares the single core-side port (port B) of the dual-port SDRAM controller between four Neo-Geo ROM requesters: C-ROM sprite fetch, P-ROM 68k program, S-ROM fix layer and M-ROM Z80 audio. It grants one requester at a time, latches its command, drives the req/ack/valid handshake toward the controller or sprite cache line, and routes read data back. One transaction is outstanding at a time. A watchdog aborts reads that never return data.

## Interface
- ADDR_W, 23, word address width per requester and toward SDRAM
- DATA_W, 16, data width
- TIMEOUT, 255, max cycles in WAIT_DATA before abort (8-bit counter, 1..255)
- STARVE_LIMIT, 16, pending-cycle age that promotes a requester (used only with the Configuration macro)

Ports:
- clk  in  1  system clock (96 MHz domain)
- reset_n  in  1  asynchronous, active-low reset
- req_i  in  4  per-requester request level; bit0 sprite, bit1 cpu, bit2 fix, bit3 audio
- we_i  in  4  per-requester write enable
- addr_i  in  4*ADDR_W  packed addresses; requester n at [n*ADDR_W +: ADDR_W]
- wdata_i  in  4*DATA_W  packed write data
- ack_o  out  4  one-cycle pulse: command accepted by SDRAM side
- valid_o  out  4  one-cycle pulse: read data on rdata_o
- rdata_o  out  DATA_W  read data, held until next read completes
- req_out  out  1  request toward SDRAM port
- we_out  out  1  write enable toward SDRAM port
- addr_out  out  ADDR_W  latched address
- data_out  out  DATA_W  latched write data
- ack_in  in  1  SDRAM accepted req_out
- valid_in  in  1  SDRAM read data valid
- data_in  in  DATA_W  SDRAM read data
- busy  out  1  high in any state other than IDLE
- grant_id  out  2  index of current/last granted requester
- timeout_o  out  1  one-cycle pulse on watchdog abort

## Operation
- States: IDLE, REQ, WAIT_DATA.
- IDLE: if any req_i bit is high, select the winner, latch its addr/we/wdata and grant_id, then go to REQ. Otherwise stay in IDLE.
- Winner selection is fixed priority: sprite > cpu > fix > audio.
- REQ: req_out=1 with the latched command. On ack_in, pulse ack_o[grant_id] and drop req_out.
  - Write: return to IDLE.
  - Read: go to WAIT_DATA and clear the watchdog.
- WAIT_DATA: on valid_in, register data_in into rdata_o, pulse valid_o[grant_id], return to IDLE.
- Watchdog abort: if the watchdog reaches TIMEOUT first, pulse timeout_o, pulse valid_o[grant_id] with rdata_o=all ones, return to IDLE.
- Latched commands complete even if req_i drops before ack_o. A requester must hold req_i until it sees ack_o, or it may be granted twice.
- ack_in while not in REQ is ignored. valid_in while not in WAIT_DATA is ignored.
- valid_in and watchdog expiry in the same cycle: valid_in wins, no timeout_o.
- Reset values: req_out=0, we_out=0, addr_out=0, data_out=0, ack_o=0, valid_o=0, rdata_o=0, busy=0, grant_id=0, timeout_o=0, state IDLE, age counters 0.
- Reset asserted mid-transaction drops req_out asynchronously. No completion pulse is issued.

## Timing
- req_i sampled in IDLE at cycle 0. Command latched at the edge ending cycle 0. req_out high from cycle 1.
- ack_o pulses in the same cycle ack_in is seen in REQ; req_out is low the next cycle.
- valid_o is registered: one cycle after valid_in.
- Minimum read: req_i at cycle 0, ack_in at cycle 1, valid_in at cycle 2, valid_o at cycle 3.
- A new arbitration is possible the cycle after returning to IDLE. Back-to-back transactions are therefore spaced by at least one IDLE cycle.
- Watchdog increments every WAIT_DATA cycle. Abort fires on the cycle the count equals TIMEOUT.

## Configuration
- NEO_ARB_STARVE_GUARD_EN defined:
  - Each requester has a 5-bit saturating age counter. It increments each cycle the requester's req_i is high and it is not the IDLE winner, and clears when it is granted.
  - A requester whose age is at least STARVE_LIMIT takes priority over non-starved requesters. Ties among starved requesters use the fixed order.
- Undefined: pure fixed priority. No age counters are synthesized.

## Test plan
- Single cpu read at 0x012345; SDRAM model acks after 2 cycles and returns 0xBEEF 3 cycles later -> addr_out=0x012345, one ack_o[1] pulse, valid_o[1] pulse with rdata_o=0xBEEF, grant_id=1, busy low after.
- Sprite and audio requesting in the same cycle -> sprite granted first (grant_id=0); audio granted on the next IDLE.
- Fix write of 0x00AA to 0x7FFFFF -> we_out=1, data_out=0x00AA, ack_o[2] pulse, return to IDLE with no valid_o.
- Read with no valid_in, TIMEOUT=255 -> timeout_o and valid_o pulse exactly 255 cycles into WAIT_DATA, rdata_o=0xFFFF.
- reset_n low during WAIT_DATA -> req_out=0 and busy=0 immediately, no valid_o pulse; a later read works normally.
- With NEO_ARB_STARVE_GUARD_EN, sprite requesting continuously and audio pending -> audio granted once its age reaches 16; without the macro, audio is never granted.

Source files
------------

// File: rtl/neo_sdram_port_arbiter.sv
// Arbitrates the SDRAM controller core port between the four Neo-Geo ROM requesters.
// Optional anti-starvation aging is enabled by defining NEO_ARB_STARVE_GUARD_EN.
module neo_sdram_port_arbiter #(
    parameter int ADDR_W       = 23,
    parameter int DATA_W       = 16,
    parameter int TIMEOUT      = 255,
    parameter int STARVE_LIMIT = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [3:0]          req_i,
    input  logic [3:0]          we_i,
    input  logic [4*ADDR_W-1:0] addr_i,
    input  logic [4*DATA_W-1:0] wdata_i,
    output logic [3:0]          ack_o,
    output logic [3:0]          valid_o,
    output logic [DATA_W-1:0]   rdata_o,
    output logic                req_out,
    output logic                we_out,
    output logic [ADDR_W-1:0]   addr_out,
    output logic [DATA_W-1:0]   data_out,
    input  logic                ack_in,
    input  logic                valid_in,
    input  logic [DATA_W-1:0]   data_in,
    output logic                busy,
    output logic [1:0]          grant_id,
    output logic                timeout_o
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ       = 2'd1,
        WAIT_DATA = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  wdog;
    logic [7:0]  wdog_nxt;
    logic [1:0]  winner;
    logic        any_req;
    logic        load;
    logic        rd_done;
    logic        rd_abort;

    function automatic logic [1:0] prio_pick(input logic [3:0] mask);
        logic [1:0] idx;
        if (mask[0])      idx = 2'd0;
        else if (mask[1]) idx = 2'd1;
        else if (mask[2]) idx = 2'd2;
        else              idx = 2'd3;
        return idx;
    endfunction

    function automatic logic [3:0] onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    assign any_req = |req_i;

`ifdef NEO_ARB_STARVE_GUARD_EN
    logic [3:0][4:0] age;
    logic [3:0]      starved;

    always_comb begin
        starved = '0;
        for (int n = 0; n < 4; n++) begin
            starved[n] = req_i[n] && (32'(age[n]) >= 32'(STARVE_LIMIT));
        end
    end

    // Starved requesters form a higher priority class; fixed order breaks ties inside it.
    assign winner = (|starved) ? prio_pick(starved) : prio_pick(req_i);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            age <= '0;
        end else begin
            for (int n = 0; n < 4; n++) begin
                if (state == IDLE && any_req && winner == 2'(n)) begin
                    age[n] <= '0;
                end else if (req_i[n] && age[n] != 5'd31) begin
                    age[n] <= age[n] + 5'd1;
                end
            end
        end
    end
`else
    assign winner = prio_pick(req_i);
`endif

    always_comb begin
        state_nxt = state;
        wdog_nxt  = wdog;
        ack_o     = '0;
        load      = 1'b0;
        rd_done   = 1'b0;
        rd_abort  = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    load      = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (ack_in) begin
                    ack_o = onehot(grant_id);
                    if (we_out) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = WAIT_DATA;
                        wdog_nxt  = '0;
                    end
                end
            end
            WAIT_DATA: begin
                wdog_nxt = wdog + 8'd1;
                // Data arriving on the expiry cycle still counts as a normal completion.
                if (valid_in) begin
                    rd_done   = 1'b1;
                    state_nxt = IDLE;
                end else if (wdog_nxt == TIMEOUT_CNT) begin
                    rd_abort  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            wdog  <= '0;
        end else begin
            state <= state_nxt;
            wdog  <= wdog_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant_id  <= '0;
            we_out    <= 1'b0;
            addr_out  <= '0;
            data_out  <= '0;
            valid_o   <= '0;
            rdata_o   <= '0;
            timeout_o <= 1'b0;
        end else begin
            if (load) begin
                grant_id <= winner;
                we_out   <= we_i[winner];
                addr_out <= addr_i[32'(winner)*ADDR_W +: ADDR_W];
                data_out <= wdata_i[32'(winner)*DATA_W +: DATA_W];
            end
            valid_o   <= (rd_done || rd_abort) ? onehot(grant_id) : 4'b0000;
            timeout_o <= rd_abort;
            if (rd_done) begin
                rdata_o <= data_in;
            end else if (rd_abort) begin
                rdata_o <= '1;
            end
        end
    end

    // Derived from the state register so an asynchronous reset drops them immediately.
    assign req_out = (state == REQ);
    assign busy    = (state != IDLE);

endmodule

// File: tb/tb_neo_sdram_port_arbiter.sv
// Directed self-checking bench for neo_sdram_port_arbiter with a small SDRAM port model.
module tb_neo_sdram_port_arbiter;
    localparam int AW = 23;
    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [3:0]      req_i = '0;
    logic [3:0]      we_i = '0;
    logic [4*AW-1:0] addr_i = '0;
    logic [4*DW-1:0] wdata_i = '0;
    logic [3:0]      ack_o;
    logic [3:0]      valid_o;
    logic [DW-1:0]   rdata_o;
    logic            req_out;
    logic            we_out;
    logic [AW-1:0]   addr_out;
    logic [DW-1:0]   data_out;
    logic            ack_in = 1'b0;
    logic            valid_in = 1'b0;
    logic [DW-1:0]   data_in = '0;
    logic            busy;
    logic [1:0]      grant_id;
    logic            timeout_o;

    neo_sdram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(255), .STARVE_LIMIT(16)) dut (
        .clk(clk), .reset_n(reset_n), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .ack_o(ack_o), .valid_o(valid_o), .rdata_o(rdata_o),
        .req_out(req_out), .we_out(we_out), .addr_out(addr_out), .data_out(data_out),
        .ack_in(ack_in), .valid_in(valid_in), .data_in(data_in), .busy(busy),
        .grant_id(grant_id), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    int req_cyc = 0;
    int ack_cnt[4];
    int val_cnt[4];
    int ack_cyc[4];
    int val_cyc[4];
    int to_cnt = 0;
    int to_cyc = 0;
    logic [DW-1:0] val_data = '0;

    // SDRAM model knobs
    int            ack_lat = 1;
    int            dat_lat = 1;
    logic [DW-1:0] rd_val = '0;
    bit            no_valid = 1'b0;
    int            rcnt = 0;
    int            dcnt = 0;
    bit            pend = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        ack_in   = 1'b0;
        valid_in = 1'b0;
        if (!reset_n) begin
            rcnt = 0;
            pend = 1'b0;
        end else if (req_out) begin
            rcnt++;
            if (rcnt >= ack_lat) begin
                ack_in = 1'b1;
                rcnt   = 0;
                if (!we_out) begin
                    pend = 1'b1;
                    dcnt = 0;
                end
            end
        end else if (pend && busy) begin
            dcnt++;
            if (dcnt >= dat_lat && !no_valid) begin
                valid_in = 1'b1;
                data_in  = rd_val;
                pend     = 1'b0;
            end
        end else begin
            pend = 1'b0;
        end
    end

    always @(negedge clk) begin
        for (int n = 0; n < 4; n++) begin
            if (ack_o[n]) begin ack_cnt[n]++; ack_cyc[n] = cyc; end
            if (valid_o[n]) begin val_cnt[n]++; val_cyc[n] = cyc; val_data = rdata_o; end
        end
        if (timeout_o) begin to_cnt++; to_cyc = cyc; end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clr();
        for (int n = 0; n < 4; n++) begin
            ack_cnt[n] = 0; val_cnt[n] = 0; ack_cyc[n] = 0; val_cyc[n] = 0;
        end
        to_cnt = 0;
        to_cyc = 0;
    endtask

    task automatic start(input int n, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        we_i[n] = we;
        addr_i[n*AW +: AW] = a;
        wdata_i[n*DW +: DW] = d;
        req_i[n] = 1'b1;
        req_cyc = cyc;
    endtask

    task automatic wait_ack(input int n, input string tag);
        bit got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (ack_o[n]) begin got = 1'b1; break; end
        end
        req_i[n] = 1'b0;
        if (!got) chk({tag, "_ack_seen"}, 32'd0, 32'd1);
    endtask

    task automatic wait_idle(input int bound, input string tag);
        bit got = 1'b0;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (!busy) begin got = 1'b1; break; end
        end
        if (!got) chk({tag, "_idle_seen"}, 32'd0, 32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        clr();
        repeat (3) tick();
        chk("rst_req_out", req_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant_id, 0);
        chk("rst_ack", ack_o, 0);
        chk("rst_valid", valid_o, 0);
        chk("rst_rdata", rdata_o, 0);
        chk("rst_timeout", timeout_o, 0);
        chk("rst_addr", addr_out, 0);
        chk("rst_we", we_out, 0);
        chk("rst_data", data_out, 0);
        reset_n = 1'b1;
        repeat (2) tick();

        // cpu read, ack after 2 REQ cycles, data 3 cycles later
        clr(); ack_lat = 2; dat_lat = 3; rd_val = 16'hBEEF;
        start(1, 1'b0, 23'h012345, 16'h0);
        wait_ack(1, "cpu_rd");
        chk("cpu_rd_addr", addr_out, 32'h012345);
        chk("cpu_rd_we", we_out, 0);
        tick();
        chk("cpu_rd_req_drop", req_out, 0);
        wait_idle(50, "cpu_rd");
        chk("cpu_rd_ack_cnt", ack_cnt[1], 1);
        chk("cpu_rd_ack_cyc", ack_cyc[1] - req_cyc, 2);
        chk("cpu_rd_val_cnt", val_cnt[1], 1);
        chk("cpu_rd_val_cyc", val_cyc[1] - req_cyc, 6);
        chk("cpu_rd_val_data", val_data, 32'hBEEF);
        chk("cpu_rd_rdata", rdata_o, 32'hBEEF);
        chk("cpu_rd_grant", grant_id, 1);
        chk("cpu_rd_busy", busy, 0);

        // minimum-latency sprite read
        tick(); clr(); ack_lat = 1; dat_lat = 1; rd_val = 16'h5A5A;
        start(0, 1'b0, 23'h000010, 16'h0);
        wait_ack(0, "min_rd");
        wait_idle(20, "min_rd");
        chk("min_rd_ack_cyc", ack_cyc[0] - req_cyc, 1);
        chk("min_rd_val_cyc", val_cyc[0] - req_cyc, 3);
        chk("min_rd_data", val_data, 32'h5A5A);
        chk("min_rd_grant", grant_id, 0);

        // sprite and audio writes requested together
        tick(); clr();
        start(0, 1'b1, 23'h000020, 16'h1111);
        start(3, 1'b1, 23'h000030, 16'h3333);
        for (int i = 0; i < 20 && req_i != 4'b0000; i++) begin
            tick();
            if (ack_o[0]) req_i[0] = 1'b0;
            if (ack_o[3]) req_i[3] = 1'b0;
        end
        wait_idle(20, "sa");
        chk("sa_sprite_ack_cyc", ack_cyc[0] - req_cyc, 1);
        chk("sa_audio_ack_cyc", ack_cyc[3] - req_cyc, 3);
        chk("sa_acks", ack_cnt[0] + ack_cnt[3], 2);
        chk("sa_no_valid", val_cnt[0] + val_cnt[3], 0);
        chk("sa_grant_last", grant_id, 3);

        // fix write to top of address range
        tick(); clr();
        start(2, 1'b1, 23'h7FFFFF, 16'h00AA);
        wait_ack(2, "fix_wr");
        chk("fix_wr_we", we_out, 1);
        chk("fix_wr_data", data_out, 32'h00AA);
        chk("fix_wr_addr", addr_out, 32'h7FFFFF);
        wait_idle(20, "fix_wr");
        chk("fix_wr_ack_cnt", ack_cnt[2], 1);
        chk("fix_wr_no_valid", val_cnt[0] + val_cnt[1] + val_cnt[2] + val_cnt[3], 0);

        // request withdrawn before ack still completes
        tick(); clr(); ack_lat = 3;
        start(1, 1'b1, 23'h000ABC, 16'h2222);
        tick();
        req_i[1] = 1'b0;
        wait_ack(1, "drop");
        chk("drop_ack_cyc", ack_cyc[1] - req_cyc, 3);
        chk("drop_addr", addr_out, 32'h000ABC);
        wait_idle(20, "drop");

        // watchdog abort
        tick(); clr(); ack_lat = 1; no_valid = 1'b1;
        start(3, 1'b0, 23'h000200, 16'h0);
        wait_ack(3, "wd");
        wait_idle(400, "wd");
        chk("wd_to_cnt", to_cnt, 1);
        chk("wd_val_cnt", val_cnt[3], 1);
        chk("wd_to_cyc", to_cyc - ack_cyc[3], 256);
        chk("wd_val_cyc", val_cyc[3], to_cyc);
        chk("wd_val_data", val_data, 32'hFFFF);
        chk("wd_rdata", rdata_o, 32'hFFFF);
        no_valid = 1'b0;

        // reset during WAIT_DATA
        tick(); clr(); no_valid = 1'b1;
        start(1, 1'b0, 23'h000300, 16'h0);
        wait_ack(1, "rst_mid");
        repeat (5) tick();
        chk("rst_mid_busy_before", busy, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_req_out", req_out, 0);
        chk("rst_mid_grant", grant_id, 0);
        repeat (3) tick();
        reset_n = 1'b1;
        no_valid = 1'b0;
        chk("rst_mid_no_valid", val_cnt[1], 0);
        chk("rst_mid_no_timeout", to_cnt, 0);
        repeat (2) tick();
        clr(); rd_val = 16'h1234;
        start(3, 1'b0, 23'h000100, 16'h0);
        wait_ack(3, "post_rst");
        wait_idle(20, "post_rst");
        chk("post_rst_val_cnt", val_cnt[3], 1);
        chk("post_rst_data", val_data, 32'h1234);
        chk("post_rst_grant", grant_id, 3);

        // sprite hammering while audio waits
        tick(); clr(); ack_lat = 1;
        start(0, 1'b1, 23'h000040, 16'h4444);
        start(3, 1'b1, 23'h000050, 16'h5555);
        for (int i = 0; i < 60; i++) begin
            tick();
            if (ack_o[3]) req_i[3] = 1'b0;
        end
        req_i = '0;
        wait_idle(20, "starve");
`ifdef NEO_ARB_STARVE_GUARD_EN
        chk("starve_audio_cnt", ack_cnt[3], 1);
        chk("starve_audio_cyc", ack_cyc[3] - req_cyc, 17);
`else
        chk("starve_audio_cnt", ack_cnt[3], 0);
`endif
        chk("starve_sprite_served", ack_cnt[0] >= 20, 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
